// File: rtl/capture_pulse_ctrl.sv
// Purpose: scan capture-clock pulse controller; on a shift_en fall it waits SETTLE cycles, then pulses per-channel clock-gate enables.
// Latency: first cap_en at E0+SETTLE, done at E0+SETTLE+pulse length; all outputs registered.
// Backpressure: none; shift_en high during SETTLE/PULSE aborts, during DONE returns to IDLE. Macro CAP_STAGGER_EN: per-channel staggered pulsing.
module capture_pulse_ctrl #(
   parameter int NCH    = 2,
   parameter int PCNT_W = 3,
   parameter int SETTLE = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic [PCNT_W-1:0] cfg_npulse,
   input  logic [NCH-1:0]    ch_mask,
   output logic [NCH-1:0]    cap_en,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_PULSE, ST_DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t            state_q, state_nx;
   logic              sh_d;
   // sh_d resets to 1, so a low shift_en right after reset must not look like
   // a fall; a capture needs shift_en=1 to have been sampled since reset.
   logic              sh_vld;
   logic [3:0]        settle_q, settle_nx;
   logic [PCNT_W-1:0] pcnt_q, pcnt_nx;
   logic [PCNT_W-1:0] npulse_q, npulse_nx;
   logic [NCH-1:0]    mask_q, mask_nx;
   logic [NCH-1:0]    cap_nx;
   logic              busy_nx, done_nx;
   logic              start;

`ifdef CAP_STAGGER_EN
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [CH_W-1:0] ch_q, ch_nx, first_ch, next_ch;
   logic            first_ok, next_ok;

   // Lowest masked-in channel overall, and lowest masked-in channel above the current one.
   always_comb begin
      first_ch = '0;
      first_ok = 1'b0;
      next_ch  = '0;
      next_ok  = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            first_ch = CH_W'(i);
            first_ok = 1'b1;
         end
         if (mask_q[i] && (i > int'(ch_q))) begin
            next_ch = CH_W'(i);
            next_ok = 1'b1;
         end
      end
   end
`endif

   assign start = sh_vld && sh_d && !shift_en;

   // Next-state logic; outputs are decoded from the next state and registered.
   always_comb begin
      state_nx  = state_q;
      settle_nx = settle_q;
      pcnt_nx   = pcnt_q;
      npulse_nx = npulse_q;
      mask_nx   = mask_q;
      cap_nx    = '0;
`ifdef CAP_STAGGER_EN
      ch_nx     = ch_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_nx  = ST_SETTLE;
               settle_nx = '0;
               npulse_nx = cfg_npulse;
               mask_nx   = ch_mask;
            end
         end
         ST_SETTLE: begin
            if (shift_en) begin
               state_nx = ST_IDLE;
            end else if (settle_q == SETTLE_LAST) begin
               if (npulse_q == '0) begin
                  state_nx = ST_DONE;
               end else begin
`ifdef CAP_STAGGER_EN
                  if (first_ok) begin
                     state_nx = ST_PULSE;
                     ch_nx    = first_ch;
                     pcnt_nx  = PCNT_W'(1);
                  end else begin
                     state_nx = ST_DONE;
                  end
`else
                  state_nx = ST_PULSE;
                  pcnt_nx  = PCNT_W'(1);
`endif
               end
            end else begin
               settle_nx = settle_q + 4'd1;
            end
         end
         ST_PULSE: begin
            if (shift_en) begin
               state_nx = ST_IDLE;
            end else if (pcnt_q == npulse_q) begin
`ifdef CAP_STAGGER_EN
               if (next_ok) begin
                  ch_nx   = next_ch;
                  pcnt_nx = PCNT_W'(1);
               end else begin
                  state_nx = ST_DONE;
               end
`else
               state_nx = ST_DONE;
`endif
            end else begin
               pcnt_nx = pcnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (shift_en) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      if (state_nx == ST_PULSE) begin
`ifdef CAP_STAGGER_EN
         cap_nx[ch_nx] = 1'b1;
`else
         cap_nx = mask_q;
`endif
      end
      busy_nx = (state_nx == ST_SETTLE) || (state_nx == ST_PULSE);
      done_nx = (state_nx == ST_DONE);
   end

   // State, counters, latched config and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sh_d     <= 1'b1;
         sh_vld   <= 1'b0;
         settle_q <= '0;
         pcnt_q   <= '0;
         npulse_q <= '0;
         mask_q   <= '0;
         cap_en   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef CAP_STAGGER_EN
         ch_q     <= '0;
`endif
      end else begin
         state_q  <= state_nx;
         sh_d     <= shift_en;
         sh_vld   <= sh_vld | shift_en;
         settle_q <= settle_nx;
         pcnt_q   <= pcnt_nx;
         npulse_q <= npulse_nx;
         mask_q   <= mask_nx;
         cap_en   <= cap_nx;
         busy     <= busy_nx;
         done     <= done_nx;
`ifdef CAP_STAGGER_EN
         ch_q     <= ch_nx;
`endif
      end
   end

endmodule

// File: tb/tb_capture_pulse_ctrl.sv
// Purpose: directed self-checking bench for capture_pulse_ctrl (NCH=2, PCNT_W=3, SETTLE=3).
// Latency: outputs sampled 1ns after each rising edge; E0 is the edge that sees the shift_en fall.
// Backpressure: n/a; expectations follow CAP_STAGGER_EN when defined.
module tb_capture_pulse_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       shift_en;
   logic [2:0] cfg_npulse;
   logic [1:0] ch_mask;
   logic [1:0] cap_en;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   capture_pulse_ctrl #(.NCH(2), .PCNT_W(3), .SETTLE(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en   (shift_en),
      .cfg_npulse (cfg_npulse),
      .ch_mask    (ch_mask),
      .cap_en     (cap_en),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic [1:0] c, input logic b, input logic d);
      chk({tag, ".cap_en"}, 32'(cap_en), 32'(c));
      chk({tag, ".busy"},   32'(busy),   32'(b));
      chk({tag, ".done"},   32'(done),   32'(d));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns just after E0.
   task automatic start_cap(input logic [2:0] n, input logic [1:0] m);
      shift_en   = 1'b1;
      cfg_npulse = n;
      ch_mask    = m;
      step();
      step();
      shift_en = 1'b0;
      step();
   endtask

   initial begin
      rst_n      = 1'b0;
      shift_en   = 1'b1;
      cfg_npulse = '0;
      ch_mask    = '0;
      #2;
      outs("reset", 2'b00, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      // npulse=2 mask=11; config changed after E0 must be ignored
      start_cap(3'd2, 2'b11);
      cfg_npulse = 3'd7;
      ch_mask    = 2'b00;
      outs("a_e0", 2'b00, 1'b1, 1'b0);
      step(); outs("a_e1", 2'b00, 1'b1, 1'b0);
      step(); outs("a_e2", 2'b00, 1'b1, 1'b0);
`ifdef CAP_STAGGER_EN
      step(); outs("a_e3", 2'b01, 1'b1, 1'b0);
      step(); outs("a_e4", 2'b01, 1'b1, 1'b0);
      step(); outs("a_e5", 2'b10, 1'b1, 1'b0);
      step(); outs("a_e6", 2'b10, 1'b1, 1'b0);
      step(); outs("a_e7", 2'b00, 1'b0, 1'b1);
`else
      step(); outs("a_e3", 2'b11, 1'b1, 1'b0);
      step(); outs("a_e4", 2'b11, 1'b1, 1'b0);
      step(); outs("a_e5", 2'b00, 1'b0, 1'b1);
`endif
      step(); outs("a_hold", 2'b00, 1'b0, 1'b1);
      shift_en = 1'b1;
      step(); outs("a_idle", 2'b00, 1'b0, 1'b0);

      // npulse=2 mask=10: only channel 1 pulses, either mode
      start_cap(3'd2, 2'b10);
      step(); step();
      outs("b_e2", 2'b00, 1'b1, 1'b0);
      step(); outs("b_e3", 2'b10, 1'b1, 1'b0);
      step(); outs("b_e4", 2'b10, 1'b1, 1'b0);
      step(); outs("b_e5", 2'b00, 1'b0, 1'b1);
      shift_en = 1'b1;
      step(); outs("b_idle", 2'b00, 1'b0, 1'b0);

      // npulse=0: straight to DONE after settle
      start_cap(3'd0, 2'b11);
      step(); outs("c_e1", 2'b00, 1'b1, 1'b0);
      step(); outs("c_e2", 2'b00, 1'b1, 1'b0);
      step(); outs("c_e3", 2'b00, 1'b0, 1'b1);
      step(); outs("c_e4", 2'b00, 1'b0, 1'b1);
      shift_en = 1'b1;
      step(); outs("c_idle", 2'b00, 1'b0, 1'b0);

      // npulse=4 mask=11, abort by shift_en sampled at E0+4
      start_cap(3'd4, 2'b11);
      step(); step(); step();
`ifdef CAP_STAGGER_EN
      outs("d_e3", 2'b01, 1'b1, 1'b0);
`else
      outs("d_e3", 2'b11, 1'b1, 1'b0);
`endif
      shift_en = 1'b1;
      step(); outs("d_e4", 2'b00, 1'b0, 1'b0);
      step(); outs("d_e5", 2'b00, 1'b0, 1'b0);
      step(); outs("d_e6", 2'b00, 1'b0, 1'b0);

      // asynchronous reset mid-PULSE, then no restart without a fresh fall
      start_cap(3'd4, 2'b11);
      step(); step(); step();
      #3;
      rst_n = 1'b0;
      #1;
      outs("e_rst", 2'b00, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         outs($sformatf("e_post%0d", k), 2'b00, 1'b0, 1'b0);
      end

      // fresh fall after reset starts a normal capture
      start_cap(3'd1, 2'b11);
      outs("f_e0", 2'b00, 1'b1, 1'b0);
      step(); step(); step();
`ifdef CAP_STAGGER_EN
      outs("f_e3", 2'b01, 1'b1, 1'b0);
      step(); outs("f_e4", 2'b10, 1'b1, 1'b0);
      step(); outs("f_e5", 2'b00, 1'b0, 1'b1);
`else
      outs("f_e3", 2'b11, 1'b1, 1'b0);
      step(); outs("f_e4", 2'b00, 1'b0, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
